seg7_scan_driver: RTL
=====================

# seg7_scan_driver

Parametrised, time-multiplexed seven-segment display driver for the stopwatch display path. It scans `NUM_DIGITS` 4-bit digit codes onto one shared cathode bus, one anode at a time. It adds hex decoding, leading-zero blanking, per-digit blink and decimal points. Display updates are tear-free: new values are loaded only at frame boundaries. It replaces the single-digit combinational cathode lookup and sits between the stopwatch counter logic and the board's anode/cathode pins.

## Interface
- `NUM_DIGITS`, 4: number of scanned digits (2..8).
- `REFRESH_DIV`, 100000: clk cycles each digit is lit (≥2).
- `BLINK_FRAMES`, 64: full scan frames per blink half-period (≥1).
- `ACTIVE_LOW`, 1: 1 means anodes, cathodes and dp are driven active-low; 0 means active-high.

Ports:
- `clk` input 1: single system clock; all logic on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `digits_in` input 4*NUM_DIGITS: digit codes; digit i is `[4i+3:4i]`, and digit 0 is rightmost.
- `load` input 1: one-cycle strobe that captures `digits_in`, `dp_in` and `blink_en`.
- `dp_in` input NUM_DIGITS: decimal-point enable per digit.
- `blink_en` input NUM_DIGITS: blink enable per digit.
- `hex_mode` input 1: 1 shows codes 10–15 as A b C d E F; 0 blanks them. Sampled live.
- `lz_blank` input 1: 1 enables leading-zero blanking. Sampled live.
- `anode` output NUM_DIGITS: digit select, one-hot in the active polarity.
- `cathode` output 7: segments {g,f,e,d,c,b,a}, bit 6 = g.
- `dp` output 1: decimal-point segment.
- `frame_start` output 1: one-cycle pulse when digit 0 becomes lit.

## Operation
**Refresh counter.**
- `rcnt` counts 0..REFRESH_DIV-1 and then wraps.
- At terminal count, `idx` advances by one; after NUM_DIGITS-1 it wraps to 0. That wrap is the frame boundary.

**Shadow/active registers.**
- `load` copies the inputs into the shadow registers and sets `pending`.
- At a frame boundary with `pending` set, shadow is copied to active and `pending` clears.
- If `load` coincides with a frame boundary, `digits_in` goes straight to active and `pending` ends cleared.
- A second `load` before the boundary overwrites the shadow; the last load wins.

**Blink.**
- The frame counter counts boundaries 0..BLINK_FRAMES-1. On wrap, `blink_phase` toggles.
- A digit with blink enabled is blanked while `blink_phase` = 1.

**Decode, active-high gfedcba:**
- 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
- 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
- A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001

**Blanking.**
- A digit is blanked when any of these holds:
  - its code is 10–15 and `hex_mode`=0;
  - it is a leading zero (see below);
  - it has blink enabled and `blink_phase` = 1.
- Leading zero: `lz_blank`=1, the digit is 0, and every higher digit is also 0. Digit 0 is never leading-zero blanked.
- A blanked digit has its anode deasserted, all cathodes off and dp off for its slot.
- The dp of an unblanked digit follows active `dp_in[idx]`.

**Polarity.** With `ACTIVE_LOW`=1, the anode, cathode and dp outputs are bitwise-inverted from the active-high values.

## Timing
- **Reset values:**
  - `anode` all inactive; `cathode` all off; `dp` off; `frame_start` 0.
  - `rcnt`, `idx`, frame counter and `blink_phase` all 0.
  - Active and shadow digits 0; `dp`/`blink_en` registers 0; `pending` 0.
- **Outputs are registered.** Outputs reflect `idx` one cycle after `idx` changes.
- **After reset release:** digit 0 is lit on the first rising edge, and `frame_start` pulses for that one cycle. Each digit then stays lit exactly REFRESH_DIV cycles.
- **Frame length:** NUM_DIGITS*REFRESH_DIV cycles.
- **Load latency:** a load is visible from the next frame start. The worst case is one full frame plus 1 cycle.
- **Reset mid-operation:** all state clears immediately and asynchronously, and any pending load is discarded.
- **Live inputs:** `hex_mode` and `lz_blank` take effect at the next digit slot output register update.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2, ACTIVE_LOW=1.

1. **Reset scan.** Release rst and load 0x1234.
   - Anode sequence is 1110, 1101, 1011, 0111, each held 4 cycles.
   - Frame is 16 cycles; `frame_start` is 1 cycle wide each frame.
   - Cathode on digit 0 (value 4) = ~1100110 = 0011001.
2. **Tear-free load.** Load 0x5678 mid-frame.
   - Current frame still shows 1234.
   - Next frame shows 5678.
   - A load coincident with the boundary shows in that frame.
3. **Hex mode.** Load 0x00AF.
   - `hex_mode`=1: digit 0 = F (~1110001), digit 1 = A.
   - `hex_mode`=0: those slots are blanked, anode held 1.
4. **Leading-zero blanking.** `lz_blank`=1.
   - Load 0x0000: digits 3–1 blanked; digit 0 shows 0.
   - Load 0x0102: only digit 3 blanked.
5. **Blink and dp.** Set `blink_en`=0001 and `dp_in`=0100.
   - Digit 0 is lit for 2 frames, then dark for 2 frames, repeating.
   - `dp`=0 only during digit-2 slots.
6. **Async reset mid-frame.** Assert rst with a load pending.
   - Outputs go inactive within the same cycle.
   - After release, the display shows 0000 and the pending value never appears.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed seven-segment driver. It scans NUM_DIGITS 4-bit codes onto
//   one shared cathode bus, lighting one anode at a time. It provides hex decode,
//   leading-zero blanking, per-digit blink and decimal points. New display values
//   are double-buffered and are applied only at frame boundaries, so a frame
//   never mixes old and new values.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   digits_in   4*NUM_DIGITS digit codes, digit 0 in [3:0] (rightmost)
//   load        one-cycle strobe capturing digits_in / dp_in / blink_en
//   dp_in       per-digit decimal point enable
//   blink_en    per-digit blink enable
//   hex_mode    1: codes 10..15 shown as A b C d E F, 0: blanked (live)
//   lz_blank    1: leading-zero blanking enabled (live)
//   anode       one-hot digit select in output polarity
//   cathode     segments {g,f,e,d,c,b,a} in output polarity
//   dp          decimal point segment in output polarity
//   frame_start one-cycle pulse when digit 0 becomes lit
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 64,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    input  logic                    hex_mode,
    input  logic                    lz_blank,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              cathode,
    output logic                    dp,
    output logic                    frame_start
);

    localparam int   RCNT_W = $clog2(REFRESH_DIV);
    localparam int   IDX_W  = $clog2(NUM_DIGITS);
    localparam int   FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic INV    = (ACTIVE_LOW != 0);

    logic [RCNT_W-1:0]       rcnt;
    logic [IDX_W-1:0]        idx;
    logic [FCNT_W-1:0]       fcnt;
    logic                    blink_phase;
    logic                    pending;
    logic [4*NUM_DIGITS-1:0] shadow_dig, act_dig;
    logic [NUM_DIGITS-1:0]   shadow_dp, act_dp;
    logic [NUM_DIGITS-1:0]   shadow_bl, act_bl;

    logic                    slot_end;
    logic                    boundary;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    higher_zero;
    logic [3:0]              code;
    logic [6:0]              seg;
    logic                    blank;
    logic [NUM_DIGITS-1:0]   onehot;

    always_comb begin
        slot_end = (rcnt == RCNT_W'(REFRESH_DIV - 1));
        boundary = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));
    end

    // A digit is a leading zero when it and every digit above it are zero.
    // Digit 0 is never part of the mask.
    always_comb begin
        higher_zero = 1'b1;
        lz_mask     = '0;
        for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
            higher_zero = higher_zero && (act_dig[4*i +: 4] == 4'd0);
            lz_mask[i]  = lz_blank && higher_zero;
        end
    end

    always_comb begin
        code = act_dig[{idx, 2'b00} +: 4];
        case (code)
            4'h0:    seg = 7'b0111111;
            4'h1:    seg = 7'b0000110;
            4'h2:    seg = 7'b1011011;
            4'h3:    seg = 7'b1001111;
            4'h4:    seg = 7'b1100110;
            4'h5:    seg = 7'b1101101;
            4'h6:    seg = 7'b1111101;
            4'h7:    seg = 7'b0000111;
            4'h8:    seg = 7'b1111111;
            4'h9:    seg = 7'b1101111;
            4'hA:    seg = 7'b1110111;
            4'hB:    seg = 7'b1111100;
            4'hC:    seg = 7'b0111001;
            4'hD:    seg = 7'b1011110;
            4'hE:    seg = 7'b1111001;
            default: seg = 7'b1110001;
        endcase
        blank  = ((code > 4'd9) && !hex_mode) || lz_mask[idx] ||
                 (act_bl[idx] && blink_phase);
        onehot = NUM_DIGITS'(1) << idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt        <= '0;
            idx         <= '0;
            fcnt        <= '0;
            blink_phase <= 1'b0;
            pending     <= 1'b0;
            shadow_dig  <= '0;
            shadow_dp   <= '0;
            shadow_bl   <= '0;
            act_dig     <= '0;
            act_dp      <= '0;
            act_bl      <= '0;
            anode       <= {NUM_DIGITS{INV}};
            cathode     <= {7{INV}};
            dp          <= INV;
            frame_start <= 1'b0;
        end else begin
            // Scan timing
            if (slot_end) begin
                rcnt <= '0;
                idx  <= boundary ? '0 : idx + 1'b1;
            end else begin
                rcnt <= rcnt + 1'b1;
            end

            // Blink frame counter
            if (boundary) begin
                if (fcnt == FCNT_W'(BLINK_FRAMES - 1)) begin
                    fcnt        <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end

            // Double buffering: a load on the boundary cycle bypasses the shadow
            if (load) begin
                shadow_dig <= digits_in;
                shadow_dp  <= dp_in;
                shadow_bl  <= blink_en;
            end
            if (boundary) begin
                if (load) begin
                    act_dig <= digits_in;
                    act_dp  <= dp_in;
                    act_bl  <= blink_en;
                end else if (pending) begin
                    act_dig <= shadow_dig;
                    act_dp  <= shadow_dp;
                    act_bl  <= shadow_bl;
                end
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end

            // Registered outputs for the slot currently selected by idx
            anode       <= (blank ? '0 : onehot) ^ {NUM_DIGITS{INV}};
            cathode     <= (blank ? 7'd0 : seg) ^ {7{INV}};
            dp          <= (!blank && act_dp[idx]) ^ INV;
            frame_start <= (rcnt == '0) && (idx == '0);
        end
    end

endmodule
